// File: rtl/pc_fetch_sequencer.sv
// PC fetch sequencer: paces instruction fetch, holds the PC across data accesses,
// selects the next-PC source and provides halt/watchdog termination. Optional counters: PC_SEQ_PERF_EN.
module pc_fetch_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             imem_ren,
  input  logic             ihit,
  input  logic             dmem_req,
  input  logic             dhit,
  input  logic             halt,
  input  logic             br_taken,
  input  logic             jr_req,
  input  logic             j_req,
  output logic             pcenable,
  output logic [1:0]       pc_sel,
  output logic             dmem_busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DMEM,
    ST_HALTED,
    ST_FAULT
  } state_t;

  state_t            r_state, w_state_next;
  logic [WAIT_W-1:0] r_wait, w_wait_next;
  logic              w_waiting;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_BOOT;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = '0;
    w_waiting    = 1'b0;
    imem_ren     = 1'b0;
    pcenable     = 1'b0;
    pc_sel       = 2'd0;
    dmem_busy    = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    case (r_state)
      ST_BOOT: w_state_next = ST_FETCH;
      ST_FETCH: begin
        imem_ren = 1'b1;
        if (ihit) begin
          // halt outranks dmem_req so a halting word never starts a data access
          if (halt)          w_state_next = ST_HALTED;
          else if (dmem_req) w_state_next = ST_DMEM;
          else               pcenable     = 1'b1;
        end else begin
          w_waiting = 1'b1;
        end
      end
      ST_DMEM: begin
        dmem_busy = 1'b1;
        if (dhit) begin
          pcenable     = 1'b1;
          w_state_next = ST_FETCH;
        end else begin
          w_waiting = 1'b1;
        end
      end
      ST_HALTED: halted = 1'b1;
      ST_FAULT:  fault  = 1'b1;
      default:   w_state_next = ST_BOOT;
    endcase

    if (w_waiting && (TIMEOUT > 0)) begin
      if (r_wait == WAIT_LAST) w_state_next = ST_FAULT;
      else                     w_wait_next  = r_wait + 1'b1;
    end

    if (pcenable) begin
      if (br_taken)    pc_sel = 2'd1;
      else if (jr_req) pc_sel = 2'd2;
      else if (j_req)  pc_sel = 2'd3;
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic [CNT_W-1:0] r_cyc_cnt, r_instr_cnt, r_stall_cnt;
  logic             w_stall;

  assign w_stall = ((r_state == ST_FETCH) && !ihit) || ((r_state == ST_DMEM) && !dhit);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cyc_cnt   <= '0;
      r_instr_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + 1'b1;
      if (pcenable) r_instr_cnt <= r_instr_cnt + 1'b1;
      if (w_stall)  r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign cyc_cnt   = r_cyc_cnt;
  assign instr_cnt = r_instr_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  assign cyc_cnt   = '0;
  assign instr_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed plus randomized bench for pc_fetch_sequencer against a cycle-level
// behavioural model of the fetch/data-wait rules.
module tb_pc_fetch_sequencer;

  localparam int TO = 4;
  localparam int CW = 32;

  localparam int M_BOOT   = 0;
  localparam int M_FETCH  = 1;
  localparam int M_DMEM   = 2;
  localparam int M_HALTED = 3;
  localparam int M_FAULT  = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          imem_ren, ihit, dmem_req, dhit, halt, br_taken, jr_req, j_req;
  logic          pcenable, dmem_busy, halted, fault;
  logic [1:0]    pc_sel;
  logic [CW-1:0] cyc_cnt, instr_cnt, stall_cnt;

  int checks   = 0;
  int failures = 0;

  int          m_mode;
  int          m_wait;
  int unsigned m_cyc, m_instr, m_stall;

  pc_fetch_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .imem_ren(imem_ren), .ihit(ihit), .dmem_req(dmem_req),
    .dhit(dhit), .halt(halt), .br_taken(br_taken), .jr_req(jr_req), .j_req(j_req),
    .pcenable(pcenable), .pc_sel(pc_sel), .dmem_busy(dmem_busy), .halted(halted),
    .fault(fault), .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_counters();
`ifdef PC_SEQ_PERF_EN
    check("cyc_cnt", cyc_cnt, m_cyc);
    check("instr_cnt", instr_cnt, m_instr);
    check("stall_cnt", stall_cnt, m_stall);
`else
    check("cyc_cnt", cyc_cnt, 0);
    check("instr_cnt", instr_cnt, 0);
    check("stall_cnt", stall_cnt, 0);
`endif
  endtask

  // Called just after a rising edge; asserts RST mid-cycle and expects
  // every output to drop before any further edge.
  task automatic apply_reset();
    RST = 1'b1;
    #2;
    m_mode = M_BOOT; m_wait = 0; m_cyc = 0; m_instr = 0; m_stall = 0;
    check("rst_imem_ren", imem_ren, 0);
    check("rst_pcenable", pcenable, 0);
    check("rst_pc_sel", pc_sel, 0);
    check("rst_dmem_busy", dmem_busy, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check_counters();
    $display("t=%0t reset asserted", $time);
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
  task automatic cycle(input logic ih, input logic dr, input logic dh, input logic hl,
                       input logic br, input logic jr, input logic j);
    logic e_pcen;
    int   e_sel;
    logic stalled;
    ihit = ih; dmem_req = dr; dhit = dh; halt = hl; br_taken = br; jr_req = jr; j_req = j;
    e_pcen  = (m_mode == M_FETCH && ih && !hl && !dr) || (m_mode == M_DMEM && dh);
    e_sel   = !e_pcen ? 0 : br ? 1 : jr ? 2 : j ? 3 : 0;
    stalled = (m_mode == M_FETCH && !ih) || (m_mode == M_DMEM && !dh);
    @(negedge CLK);
    check("imem_ren", imem_ren, m_mode == M_FETCH);
    check("pcenable", pcenable, e_pcen);
    check("pc_sel", pc_sel, e_sel);
    check("dmem_busy", dmem_busy, m_mode == M_DMEM);
    check("halted", halted, m_mode == M_HALTED);
    check("fault", fault, m_mode == M_FAULT);
    check_counters();
    $display("t=%0t mode=%0d ihit=%0b dreq=%0b dhit=%0b halt=%0b br/jr/j=%0b%0b%0b -> pcen=%0b sel=%0d",
             $time, m_mode, ih, dr, dh, hl, br, jr, j, pcenable, pc_sel);
    m_cyc++;
    if (e_pcen) m_instr++;
    if (stalled) m_stall++;
    case (m_mode)
      M_BOOT: m_mode = M_FETCH;
      M_FETCH, M_DMEM: begin
        if (!stalled) begin
          m_wait = 0;
          if (m_mode == M_FETCH && hl)      m_mode = M_HALTED;
          else if (m_mode == M_FETCH && dr) m_mode = M_DMEM;
          else                              m_mode = M_FETCH;
        end else if (m_wait == TO - 1) begin
          m_wait = 0;
          m_mode = M_FAULT;
        end else begin
          m_wait++;
        end
      end
      default: ;
    endcase
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1'b0; ihit = 0; dmem_req = 0; dhit = 0; halt = 0; br_taken = 0; jr_req = 0; j_req = 0;
    m_mode = M_BOOT; m_wait = 0; m_cyc = 0; m_instr = 0; m_stall = 0;
    @(posedge CLK); #1;

    // 1: straight-line fetch
    apply_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0, 0, 0);
`ifdef PC_SEQ_PERF_EN
    check("instr_after_10", instr_cnt, 10);
`endif

    // 2: load/store with dhit three cycles late
    apply_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 1, 0);
`ifdef PC_SEQ_PERF_EN
    check("stall_after_dmem", stall_cnt, 3);
`endif
    cycle(1, 0, 0, 0, 0, 0, 0);

    // 3: redirect priority
    cycle(1, 0, 0, 0, 1, 1, 1);
    cycle(1, 0, 0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 1, 0, 1, 0, 0);

    // 4: halt beats dmem_req, then absorbing
    cycle(1, 1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 0, 1, 0, 0, 0, 1);
    check("halted_sticky", halted, 1);
    apply_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);

    // 5: watchdog fires after exactly TO starved fetch cycles
    apply_reset();
    cycle(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    check("fault_after_timeout", fault, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0, 0, 0);
    apply_reset();
    cycle(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("no_fault_hit_on_last", fault, 0);

    // 6: reset in the middle of a data wait
    apply_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    dmem_req = 1'b1; br_taken = 1'b1;
    apply_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0);

    // randomized traffic
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      if ((m_mode == M_HALTED || m_mode == M_FAULT) && $urandom_range(0, 3) == 0) begin
        apply_reset();
      end else begin
        cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 7,
              $urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom), 1'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
